// File: rtl/riscv_pkg.sv
// Shared core types: memory arbiter FSM encoding and requester ids.
// Purely declarative; no logic, no latency, no flow control.
// State values stay plain logic constants so existing netlists keep their encoding.
package riscv_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE    = 2'd0;
    localparam arb_state_t ARB_WAIT_IF = 2'd1;
    localparam arb_state_t ARB_WAIT_DM = 2'd2;

    localparam logic ARB_OWNER_IF = 1'b0;
    localparam logic ARB_OWNER_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port I/D memory between fetch and load/store, one transaction in flight.
// Latency: grant is combinational in an issue slot; response adds no cycles to memory latency.
// Backpressure: requesters hold *_req until *_gnt; MEM_ARB_STARVE_GUARD_EN bounds DM-over-IF priority.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic                    dm_gnt,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_t state;
    arb_state_t state_nxt;

    logic issue_slot;
    logic force_if;
    logic dm_win;
    logic if_win;
    logic owner;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts DM wins that overtook a waiting fetch; any fetch grant or idle fetch side resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (dm_gnt && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_if            = 1'b0;
`endif

    // Outputs are gated by rst_n so everything reads 0 while reset is held.
    always_comb begin
        issue_slot = rst_n && ((state == ARB_IDLE) || mem_rvalid);
        dm_win     = issue_slot && dm_req && !force_if;
        if_win     = issue_slot && if_req && !dm_win;
        owner      = dm_win ? ARB_OWNER_DM : ARB_OWNER_IF;
    end

    always_comb begin
        if_gnt    = if_win;
        dm_gnt    = dm_win;
        mem_req   = if_win || dm_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            if (owner == ARB_OWNER_DM) begin
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                mem_be    = dm_be;
            end else begin
                mem_addr  = if_addr;
                mem_be    = {BE_WIDTH{1'b1}};
            end
        end
    end

    // A response in IDLE belongs to an abandoned transaction and is dropped here.
    always_comb begin
        if_rvalid = rst_n && mem_rvalid && (state == ARB_WAIT_IF);
        dm_rvalid = rst_n && mem_rvalid && (state == ARB_WAIT_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

    always_comb begin
        state_nxt = state;
        if (issue_slot) begin
            if (dm_win) begin
                state_nxt = ARB_WAIT_DM;
            end else if (if_win) begin
                state_nxt = ARB_WAIT_IF;
            end else begin
                state_nxt = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified instruction/data memory between the fetch stage (IF) and the load/store stage (DM) of the RISC-V core. Requests are arbitrated, with data taking priority by default, and at most one transaction is outstanding at a time. Each response is routed back to the requester that issued it. The arbiter sits between the core's fetch/memory stages and the memory macro; the pipeline stalls on the missing `*_gnt` / `*_rvalid`.

## Interface
- `ADDR_WIDTH`, 32: address width of all address ports.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `STARVE_LIMIT`, 4: consecutive DM grants allowed while IF waits (used only with the starvation guard).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in ADDR_WIDTH: fetch address.
- `if_gnt` out 1: one-cycle pulse; request accepted.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out DATA_WIDTH: fetch data.
- `dm_req` in 1: data request; held with all `dm_*` inputs stable until `dm_gnt`.
- `dm_we` in 1: 1 for a store, 0 for a load.
- `dm_addr` in ADDR_WIDTH: data address.
- `dm_wdata` in DATA_WIDTH: store data.
- `dm_be` in DATA_WIDTH/8: store byte enables.
- `dm_gnt` out 1: one-cycle pulse; request accepted.
- `dm_rvalid` out 1: load data valid, or store completed.
- `dm_rdata` out DATA_WIDTH: load data.
- `mem_req` out 1: memory command valid.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_be` out DATA_WIDTH/8: memory byte enables.
- `mem_rvalid` in 1: memory response for the outstanding command; returned for both reads and writes, at least 1 cycle after `mem_req`.
- `mem_rdata` in DATA_WIDTH: memory read data.

## Operation
**FSM states**
- `ARB_IDLE`: no transaction outstanding.
- `ARB_WAIT_IF`: an IF transaction is outstanding.
- `ARB_WAIT_DM`: a DM transaction is outstanding.

**Issue slot.** A new command can issue when the FSM is in `ARB_IDLE`, or when it is in a WAIT state and `mem_rvalid`=1 that cycle (back-to-back issue).
- The arbitration winner gets `mem_req`=1 and its `*_gnt`=1 in the same cycle (combinational from `*_req`).
- The FSM then moves to `ARB_WAIT_IF` or `ARB_WAIT_DM`.
- With no request in the issue slot, the FSM goes to (or stays in) `ARB_IDLE`.

**Arbitration**
- Default: if `dm_req`, DM wins; else if `if_req`, IF wins.
- Both requests in the same cycle resolve to DM, unless the starvation guard forces IF (see Configuration).

**Command mux**
- `mem_addr` / `mem_we` / `mem_wdata` / `mem_be` come from the winner; IF commands drive `mem_we`=0 and `mem_be`=all ones.
- When `mem_req`=0, all `mem_*` command outputs are 0.

**Response routing**
- `if_rvalid` = `mem_rvalid` AND state `ARB_WAIT_IF`.
- `dm_rvalid` = `mem_rvalid` AND state `ARB_WAIT_DM`.
- `*_rdata` = `mem_rdata` when the matching `*_rvalid`=1, else 0.
- `mem_rvalid` in `ARB_IDLE` is ignored; it is never forwarded to either requester.

**Reset**
- All outputs are 0; FSM goes to `ARB_IDLE`; the starvation counter goes to 0.
- Reset during a WAIT state abandons the transaction; its late `mem_rvalid` is dropped per the `ARB_IDLE` rule.

## Timing
- Grant latency: 0 cycles from `*_req` in an issue slot.
- Response latency: equal to the memory latency, with no added cycles.
- Throughput: one command per memory latency; for a 1-cycle memory, one command per cycle.
- `*_gnt` is never asserted outside an issue slot.
- `if_gnt` and `dm_gnt` are never high together.
- `if_rvalid` and `dm_rvalid` are never high together.
- A requester may deassert `*_req` only after its grant; the arbiter does not check this.

## Configuration
**`MEM_ARB_STARVE_GUARD_EN` defined:**
- A counter saturating at `STARVE_LIMIT` increments on every `dm_gnt` issued while `if_req`=1.
- The counter clears on `if_gnt`, or in any cycle with `if_req`=0.
- When the counter equals `STARVE_LIMIT` and `if_req`=1, IF wins the next issue slot even if `dm_req`=1.

**Undefined:** strict DM priority with no counter logic; `STARVE_LIMIT` is unused.

## Structure
- `riscv_pkg` gains `arb_state_t` (`ARB_IDLE`, `ARB_WAIT_IF`, `ARB_WAIT_DM`) and the `ARB_OWNER_IF` / `ARB_OWNER_DM` constants.
- Single module; no sub-module is warranted.

## Test plan
1. **IF-only read:** `if_req`=1, `if_addr`=0x100, memory latency 1, `mem_rdata`=0x00500093 → `if_gnt` pulse in cycle 0; `if_rvalid`=1 with `if_rdata`=0x00500093 in cycle 1.
2. **Simultaneous requests:** `if_req`=`dm_req`=1 in the same cycle with a load to 0x2000 → `dm_gnt` first and `mem_addr`=0x2000; `if_gnt` in the response cycle (back-to-back), `mem_addr`=IF address.
3. **Store:** `dm_we`=1, `dm_addr`=0x3004, `dm_wdata`=0xDEADBEEF, `dm_be`=0b0011 → `mem_we`=1, `mem_be`=0b0011; `dm_rvalid` pulses on the write ack; `if_rvalid` stays 0.
4. **Starvation guard** (`MEM_ARB_STARVE_GUARD_EN`, `STARVE_LIMIT`=4): `dm_req` held high for 10 transactions while `if_req`=1 → exactly 4 `dm_gnt`, then 1 `if_gnt`, then DM resumes.
5. **Reset mid-transaction:** `rst_n` low during `ARB_WAIT_DM`, then release; stale `mem_rvalid`=1 arrives → no `*_rvalid`; all outputs read 0 while reset is asserted.
6. **Latency 3 memory:** IF request → no further grant for 3 cycles while a DM request waits; `dm_gnt` is asserted in the same cycle as `if_rvalid`.
